// File: rtl/decoder_buf.sv
// Small FIFO of 3-bit codes; the head code is presented as a one-hot byte.
// Status outputs come only from registered state, so no input reaches any output combinationally.
module decoder_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [7:0]               out,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'h01 << code;
  endfunction

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign out       = out_valid ? onehot8(mem_q[rd_ptr_q]) : 8'h00;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: an empty buffer masks its contents from out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

endmodule

// File: tb/tb_decoder_buf.sv
// Directed bench for decoder_buf (DEPTH=4) with immediate-assertion checks.
module tb_decoder_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out;
  logic       out_ready;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  decoder_buf #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] e_cnt, input logic [7:0] e_out);
    chk({tag, ".count"}, 32'(count), 32'(e_cnt));
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_cnt != 3'd0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_cnt < 3'd4));
  endtask

  initial begin
    logic [2:0] q[$];
    logic [2:0] c;

    rst_n = 1'b0; in_valid = 1'b0; in_code = 3'd0; out_ready = 1'b0;
    #2;
    chk_state("reset", 3'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming 7..0 with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(7 - i);
      tick();
      chk_state($sformatf("stream%0d", i), 3'd1, 8'h80 >> i);
    end
    in_valid = 1'b0;
    tick();
    chk_state("stream_drain", 3'd0, 8'h00);

    // Fill while stalled: 3,0,5,7
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code = 3'd3; tick(); chk_state("fill1", 3'd1, 8'h08);
    in_code = 3'd0; tick(); chk_state("fill2", 3'd2, 8'h08);
    in_code = 3'd5; tick(); chk_state("fill3", 3'd3, 8'h08);
    in_code = 3'd7; tick(); chk_state("fill4", 3'd4, 8'h08);
    in_code = 3'd1; tick(); chk_state("drop5", 3'd4, 8'h08);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(); chk_state("pop1", 3'd3, 8'h01);
    tick(); chk_state("pop2", 3'd2, 8'h20);
    tick(); chk_state("pop3", 3'd1, 8'h80);
    tick(); chk_state("pop4", 3'd0, 8'h00);

    // Full then a single pop: in_ready returns only after the edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_code = 3'(i);
      tick();
    end
    chk_state("full", 3'd4, 8'h02);
    in_code   = 3'd6;
    out_ready = 1'b1;
    tick(); chk_state("full_pop", 3'd3, 8'h04);
    out_ready = 1'b0;
    in_code   = 3'd5;
    tick(); chk_state("refill", 3'd4, 8'h04);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(); chk_state("dr1", 3'd3, 8'h08);
    tick(); chk_state("dr2", 3'd2, 8'h10);

    // Simultaneous push/pop at count=2, pointers wrap several times
    q = '{3'd4, 3'd5};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c = 3'((3 * i + 1) % 8);
      in_code = c;
      q.push_back(c);
      void'(q.pop_front());
      tick();
      chk_state($sformatf("pp%0d", i), 3'd2, 8'h01 << q[0]);
    end

    // Idle with scrambled in_code and a stalled consumer
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_code = 'x;
      tick();
      chk_state($sformatf("idle%0d", i), 3'd2, 8'h01 << q[0]);
    end

    // Reach count=3, then an asynchronous reset between edges
    in_valid = 1'b1;
    in_code  = 3'd6;
    tick(); chk_state("pre_rst", 3'd3, 8'h01 << q[0]);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_state("async_rst", 3'd0, 8'h00);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd2;
    tick(); chk_state("post_rst", 3'd1, 8'h04);
    in_valid = 1'b0;
    tick(); chk_state("post_hold", 3'd1, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
